tcb_lite_arbiter: RTL and testbench

//  Shares one TCB-Lite subordinate port between IFN TCB-Lite managers.
//  - Round-robin (or fixed-priority) arbitration of requests.
//  - Grant locked for the whole backpressure stall.
//  - Responses routed back to the issuing manager DLY cycles after the transfer.
//  - Sits between CPU/DMA managers and a shared memory or peripheral bus.

---
 rtl/tcb_lite_arbiter_if.sv | 27 ++
 rtl/tcb_lite_arbiter.sv | 106 ++++++++++
 tb/tb_tcb_lite_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcb_lite_arbiter_if.sv
// Manager- and subordinate-side signal bundle of the TCB-Lite arbiter.
// master: the surrounding system (managers plus subordinate); slave: the arbiter itself.
interface tcb_lite_arbiter_if #(
    parameter int unsigned IFN   = 2,
    parameter int unsigned REQ_W = 70,
    parameter int unsigned RSP_W = 33
);
    logic [IFN-1:0]       man_vld;
    logic [IFN-1:0]       man_rdy;
    logic [IFN*REQ_W-1:0] man_req;
    logic [RSP_W-1:0]     man_rsp;
    logic [IFN-1:0]       man_rsp_vld;
    logic                 sub_vld;
    logic                 sub_rdy;
    logic [REQ_W-1:0]     sub_req;
    logic [RSP_W-1:0]     sub_rsp;

    modport master (
        output man_vld, man_req, sub_rdy, sub_rsp,
        input  man_rdy, man_rsp, man_rsp_vld, sub_vld, sub_req
    );

    modport slave (
        input  man_vld, man_req, sub_rdy, sub_rsp,
        output man_rdy, man_rsp, man_rsp_vld, sub_vld, sub_req
    );
endinterface

// File: rtl/tcb_lite_arbiter.sv
// Shares one TCB-Lite subordinate between IFN managers: round-robin or fixed-priority grant,
// grant locked across backpressure, responses routed back through a DLY-deep index pipe.
module tcb_lite_arbiter #(
    parameter int unsigned IFN   = 2,
    parameter int unsigned DLY   = 1,
    parameter int unsigned REQ_W = 70,
    parameter int unsigned RSP_W = 33,
    parameter bit          RR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    tcb_lite_arbiter_if.slave bus
);
    localparam int unsigned IW = (IFN > 1) ? $clog2(IFN) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] lck_idx_q;
    logic          lck_q;
    logic [IW-1:0] sel;
    logic [IW-1:0] grant;
    logic          sub_trn;
    int unsigned   cand;

    // Descending scan: the last hit is the candidate closest to the search start.
    always_comb begin
        sel  = ptr_q;
        cand = 0;
        for (int k = int'(IFN) - 1; k >= 0; k--) begin
            if (RR) cand = (32'(ptr_q) + 32'(k)) % IFN;
            else    cand = 32'(k);
            if (bus.man_vld[cand]) sel = IW'(cand);
        end
    end

    assign grant   = lck_q ? lck_idx_q : sel;
    assign sub_trn = bus.sub_vld & bus.sub_rdy;

    always_comb begin
        bus.sub_vld = 1'b0;
        bus.sub_req = '0;
        bus.man_rdy = '0;
        for (int i = 0; i < int'(IFN); i++) begin
            if (grant == IW'(i)) begin
                bus.sub_vld    = bus.man_vld[i];
                bus.sub_req    = bus.man_req[i*REQ_W +: REQ_W];
                bus.man_rdy[i] = bus.sub_rdy;
            end
        end
    end

    assign bus.man_rsp = bus.sub_rsp[RSP_W-1:0];

    // A stalled request pins the grant until it transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            lck_q     <= 1'b0;
            lck_idx_q <= '0;
        end else begin
            if (sub_trn) begin
                lck_q <= 1'b0;
            end else if (bus.sub_vld) begin
                lck_q     <= 1'b1;
                lck_idx_q <= grant;
            end
            if (RR && sub_trn) begin
                ptr_q <= (grant == IW'(IFN - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    generate
        if (DLY == 0) begin : g_nodly
            always_comb begin
                bus.man_rsp_vld = '0;
                for (int i = 0; i < int'(IFN); i++) begin
                    bus.man_rsp_vld[i] = sub_trn && (grant == IW'(i));
                end
            end
        end else begin : g_pipe
            logic [DLY-1:0] pv_q;
            logic [IW-1:0]  pi_q [DLY];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pv_q <= '0;
                    for (int k = 0; k < int'(DLY); k++) pi_q[k] <= '0;
                end else begin
                    pv_q[0] <= sub_trn;
                    pi_q[0] <= grant;
                    for (int k = 1; k < int'(DLY); k++) begin
                        pv_q[k] <= pv_q[k-1];
                        pi_q[k] <= pi_q[k-1];
                    end
                end
            end

            always_comb begin
                bus.man_rsp_vld = '0;
                for (int i = 0; i < int'(IFN); i++) begin
                    bus.man_rsp_vld[i] = pv_q[DLY-1] && (pi_q[DLY-1] == IW'(i));
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_tcb_lite_arbiter.sv
// Bench for tcb_lite_arbiter: three configurations, directed stimulus, and a response
// scoreboard popped by a negedge monitor.
module tb_tcb_lite_arbiter;
    localparam int unsigned REQ_W = 70;
    localparam int unsigned RSP_W = 33;

    typedef struct {
        logic [2:0]       oh;
        logic [RSP_W-1:0] rsp;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // a: IFN=2 DLY=1 RR; b: IFN=3 DLY=2 RR; c: IFN=3 DLY=0 fixed priority
    tcb_lite_arbiter_if #(.IFN(2), .REQ_W(REQ_W), .RSP_W(RSP_W)) a_if ();
    tcb_lite_arbiter_if #(.IFN(3), .REQ_W(REQ_W), .RSP_W(RSP_W)) b_if ();
    tcb_lite_arbiter_if #(.IFN(3), .REQ_W(REQ_W), .RSP_W(RSP_W)) c_if ();

    tcb_lite_arbiter #(.IFN(2), .DLY(1), .REQ_W(REQ_W), .RSP_W(RSP_W), .RR(1'b1)) u_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    tcb_lite_arbiter #(.IFN(3), .DLY(2), .REQ_W(REQ_W), .RSP_W(RSP_W), .RR(1'b1)) u_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );
    tcb_lite_arbiter #(.IFN(3), .DLY(0), .REQ_W(REQ_W), .RSP_W(RSP_W), .RR(1'b0)) u_c (
        .clk(clk), .rst(rst), .bus(c_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [REQ_W-1:0] req_pat(int i);
        return {6'(i + 1), 32'hC0DE_0000 | 32'(i), 32'h1234_5678 ^ 32'(i * 7)};
    endfunction

    function automatic logic [RSP_W-1:0] rsp_pat(int c);
        return {c[0], 32'(c) * 32'h9E37_79B9};
    endfunction

    assign a_if.sub_rsp = rsp_pat(cyc);
    assign b_if.sub_rsp = rsp_pat(cyc + 1000);
    assign c_if.sub_rsp = rsp_pat(cyc + 2000);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [REQ_W-1:0] act, logic [REQ_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_grant(string name, logic [2:0] rdy, logic vld, logic [REQ_W-1:0] req,
                             logic [2:0] rdy_exp, logic vld_exp, int g);
        chk({name, "_rdy"}, REQ_W'(rdy), REQ_W'(rdy_exp));
        chk({name, "_vld"}, REQ_W'(vld), REQ_W'(vld_exp));
        if (vld_exp) chk({name, "_req"}, req, req_pat(g));
    endtask

    task automatic ga(string n, logic [2:0] rdy_exp, logic vld_exp, int g);
        chk_grant(n, 3'(a_if.man_rdy), a_if.sub_vld, a_if.sub_req, rdy_exp, vld_exp, g);
    endtask
    task automatic gb(string n, logic [2:0] rdy_exp, logic vld_exp, int g);
        chk_grant(n, b_if.man_rdy, b_if.sub_vld, b_if.sub_req, rdy_exp, vld_exp, g);
    endtask
    task automatic gc(string n, logic [2:0] rdy_exp, logic vld_exp, int g);
        chk_grant(n, c_if.man_rdy, c_if.sub_vld, c_if.sub_req, rdy_exp, vld_exp, g);
    endtask

    // Expected response for a transfer completing at the end of the current cycle.
    task automatic push(int which, int mgr, int dly, int ofs);
        exp_t e;
        e.oh  = 3'(1 << mgr);
        e.rsp = rsp_pat(cyc + dly + ofs);
        e.due = cyc + dly;
        case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic mon(int which, string name, logic [2:0] oh, logic [RSP_W-1:0] rsp);
        exp_t e;
        int   sz;
        if (oh == 3'b000) return;
        n_chk++;
        sz = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
        if (sz == 0) begin
            n_fail++;
            $display("FAIL %s_rsp: got man_rsp_vld %b at cycle %0d, expected none", name, oh, cyc);
            return;
        end
        case (which)
            0:       e = q_a.pop_front();
            1:       e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
        if (oh !== e.oh || rsp !== e.rsp || cyc != e.due) begin
            n_fail++;
            $display("FAIL %s_rsp: got vld %b rsp %h cycle %0d, expected vld %b rsp %h cycle %0d",
                     name, oh, rsp, cyc, e.oh, e.rsp, e.due);
        end
    endtask

    always @(negedge clk) begin
        mon(0, "a", 3'(a_if.man_rsp_vld), a_if.man_rsp);
        mon(1, "b", b_if.man_rsp_vld, b_if.man_rsp);
        mon(2, "c", c_if.man_rsp_vld, c_if.man_rsp);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t1_rdy [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
        logic [2:0] t3_rdy [3] = '{3'b001, 3'b010, 3'b001};
        logic [2:0] t6_rdy [3] = '{3'b100, 3'b001, 3'b100};
        int         t1_g [4]   = '{0, 1, 0, 1};
        int         t3_g [3]   = '{0, 1, 0};
        int         t6_g [3]   = '{2, 0, 2};

        a_if.man_vld = '0; a_if.sub_rdy = 1'b0;
        b_if.man_vld = '0; b_if.sub_rdy = 1'b0;
        c_if.man_vld = '0; c_if.sub_rdy = 1'b0;
        for (int i = 0; i < 2; i++) a_if.man_req[i*REQ_W +: REQ_W] = req_pat(i);
        for (int i = 0; i < 3; i++) b_if.man_req[i*REQ_W +: REQ_W] = req_pat(i);
        for (int i = 0; i < 3; i++) c_if.man_req[i*REQ_W +: REQ_W] = req_pat(i);

        // Reset: combinational path follows inputs with grant 0, no response valid.
        #1 rst = 1'b0;
        a_if.man_vld = 2'b11;
        a_if.sub_rdy = 1'b1;
        #2;
        ga("rst_a", 3'b001, 1'b1, 0);
        chk("rst_rsp_vld_a", REQ_W'(a_if.man_rsp_vld), '0);
        chk("rst_rsp_vld_b", REQ_W'(b_if.man_rsp_vld), '0);
        a_if.man_vld = '0;
        tick();
        tick();
        rst = 1'b1;

        // 1: round-robin alternation with continuous requests.
        a_if.man_vld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #2 ga("t1_rr", t1_rdy[k], 1'b1, t1_g[k]);
            push(0, t1_g[k], 1, 0);
            tick();
        end
        a_if.man_vld = '0;
        tick();

        // 2: backpressure locks the grant on manager 1.
        a_if.man_vld = 2'b10;
        a_if.sub_rdy = 1'b0;
        #2 ga("t2_stall1", 3'b000, 1'b1, 1);
        tick();
        a_if.man_vld = 2'b11;
        #2 ga("t2_stall2", 3'b000, 1'b1, 1);
        tick();
        #2 ga("t2_stall3", 3'b000, 1'b1, 1);
        tick();
        a_if.sub_rdy = 1'b1;
        #2 ga("t2_release", 3'b010, 1'b1, 1);
        push(0, 1, 1, 0);
        tick();
        #2 ga("t2_next", 3'b001, 1'b1, 0);
        push(0, 0, 1, 0);
        tick();
        a_if.man_vld = '0;
        tick();
        tick();

        // 3: DLY=2 back-to-back responses, man_rsp passes sub_rsp through.
        b_if.sub_rdy = 1'b1;
        b_if.man_vld = 3'b011;
        for (int k = 0; k < 3; k++) begin
            #2 gb("t3_b2b", t3_rdy[k], 1'b1, t3_g[k]);
            push(1, t3_g[k], 2, 1000);
            tick();
        end
        b_if.man_vld = '0;
        tick();
        tick();
        tick();

        // 6: requesters 0 and 2 with ptr=1; index 1 skipped, ptr wraps.
        b_if.man_vld = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #2 gb("t6_skip", t6_rdy[k], 1'b1, t6_g[k]);
            push(1, t6_g[k], 2, 1000);
            tick();
        end
        b_if.man_vld = '0;
        tick();
        tick();
        tick();

        // 5: reset with the DLY=2 route pipe full drops in-flight responses.
        b_if.man_vld = 3'b011;
        tick();
        tick();
        b_if.man_vld = '0;
        rst = 1'b0;
        #1 chk("t5_flush", REQ_W'(b_if.man_rsp_vld), '0);
        tick();
        rst = 1'b1;
        b_if.man_vld = 3'b110;
        #2 gb("t5_ptr0", 3'b010, 1'b1, 1);
        chk("t5_rsp_vld0", REQ_W'(b_if.man_rsp_vld), '0);
        push(1, 1, 2, 1000);
        tick();
        b_if.man_vld = '0;
        #2 chk("t5_rsp_vld1", REQ_W'(b_if.man_rsp_vld), '0);
        tick();
        tick();
        tick();

        // 4: fixed priority, DLY=0 same-cycle responses.
        c_if.sub_rdy = 1'b1;
        c_if.man_vld = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #2 gc("t4_fixed", 3'b001, 1'b1, 0);
            push(2, 0, 0, 2000);
            tick();
        end
        c_if.man_vld = 3'b110;
        #2 gc("t4_mid", 3'b010, 1'b1, 1);
        push(2, 1, 0, 2000);
        tick();
        c_if.man_vld = 3'b100;
        #2 gc("t4_low", 3'b100, 1'b1, 2);
        push(2, 2, 0, 2000);
        tick();
        c_if.man_vld = 3'b000;
        #2 gc("t4_idle", 3'b001, 1'b0, 0);
        tick();
        c_if.man_vld = 3'b010;
        c_if.sub_rdy = 1'b0;
        #2 gc("t4_stall", 3'b000, 1'b1, 1);
        tick();
        c_if.man_vld = 3'b011;
        c_if.sub_rdy = 1'b1;
        #2 gc("t4_locked", 3'b010, 1'b1, 1);
        push(2, 1, 0, 2000);
        tick();
        #2 gc("t4_after", 3'b001, 1'b1, 0);
        push(2, 0, 0, 2000);
        tick();
        c_if.man_vld = '0;
        tick();
        tick();
        tick();

        chk("drain_a", REQ_W'(q_a.size()), '0);
        chk("drain_b", REQ_W'(q_b.size()), '0);
        chk("drain_c", REQ_W'(q_c.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
